hiscore_ctrl: RTL and testbench

Sequencer that moves high-score table bytes between the host loader (ioctl upload/download) and the arcade core's hiscore RAM port (hs_address / hs_data_in / hs_data_out / hs_write / hs_access). It requests a game pause and waits for a vertical-blank boundary before taking the port. It then streams bytes one at a time with ioctl_wait back-pressure and releases the port when the host session ends. It sits in the system top between the ioctl bus and the core instance, in the clk_12 domain.

---
 rtl/hiscore_ctrl_if.sv | 32 +++
 rtl/hiscore_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hiscore_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_ctrl_if.sv
// Bus bundle between the host loader, the core's hiscore RAM port
// and hiscore_ctrl.
interface hiscore_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_write;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        hs_access;
    logic [6:0]  hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;

    modport master (
        output ioctl_download, ioctl_upload, ioctl_write, ioctl_rd,
        output ioctl_addr, ioctl_dout, ioctl_index, hs_data_out,
        input  ioctl_din, ioctl_wait, hs_access, hs_address,
        input  hs_data_in, hs_write
    );

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_write, ioctl_rd,
        input  ioctl_addr, ioctl_dout, ioctl_index, hs_data_out,
        output ioctl_din, ioctl_wait, hs_access, hs_address,
        output hs_data_in, hs_write
    );
endinterface

// File: rtl/hiscore_ctrl.sv
// Hiscore table sequencer: pauses the core, waits for vblank, then
// streams table bytes between the ioctl host and the hiscore RAM port.
module hiscore_ctrl #(
    parameter logic [7:0] HS_INDEX = 8'd4,
    parameter int         HS_BYTES = 128,
    parameter int         SETTLE   = 16
) (
    input  logic           clk_12,
    input  logic           reset_n,
    hiscore_ctrl_if.slave  bus,
    input  logic           vblank,
    output logic           pause_req,
    output logic           hs_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_SETTLE, S_ACTIVE,
        S_WR, S_RD0, S_RD1, S_RELEASE
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);
    localparam logic [127:0] LIM_MASK = (HS_BYTES >= 128) ?
        {128{1'b1}} : ((128'd1 << HS_BYTES) - 128'd1);

    state_t       r_state;
    logic         r_dl_q;
    logic         r_ul_q;
    logic         r_vb_q;
    logic         r_mode_dl;
    logic         r_end;
    logic [7:0]   r_cnt;
    logic [127:0] r_mask;
    logic         r_pause;
    logic         r_wait;
    logic         r_access;
    logic         r_write;
    logic         r_loaded;
    logic [6:0]   r_addr;
    logic [7:0]   r_wdata;
    logic [7:0]   r_din;

    logic w_dl_rise;
    logic w_ul_rise;
    logic w_hs_sel;
    logic w_vb_rise;
    logic w_fall;
    logic w_end;
    logic w_in_rng;
    logic w_full;

    assign w_dl_rise = bus.ioctl_download & ~r_dl_q;
    assign w_ul_rise = bus.ioctl_upload & ~r_ul_q;
    assign w_hs_sel  = (bus.ioctl_index == HS_INDEX);
    assign w_vb_rise = vblank & ~r_vb_q;
    assign w_fall    = r_mode_dl ? (~bus.ioctl_download & r_dl_q)
                                 : (~bus.ioctl_upload & r_ul_q);
    assign w_end     = w_fall | r_end;
    assign w_in_rng  = (bus.ioctl_addr < 25'(HS_BYTES));
    assign w_full    = &(r_mask | ~LIM_MASK);

    // Session sequencer; every output is a register written here.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_dl_q    <= 1'b0;
            r_ul_q    <= 1'b0;
            r_vb_q    <= 1'b0;
            r_mode_dl <= 1'b0;
            r_end     <= 1'b0;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_pause   <= 1'b0;
            r_wait    <= 1'b0;
            r_access  <= 1'b0;
            r_write   <= 1'b0;
            r_loaded  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_din     <= '0;
        end else begin
            r_dl_q  <= bus.ioctl_download;
            r_ul_q  <= bus.ioctl_upload;
            r_vb_q  <= vblank;
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs_sel && (w_dl_rise || w_ul_rise)) begin
                        r_mode_dl <= w_dl_rise;
                        r_mask    <= '0;
                        r_end     <= 1'b0;
                        r_pause   <= 1'b1;
                        r_wait    <= 1'b1;
                        r_state   <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (w_fall) begin
                        r_pause <= 1'b0;
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_vb_rise) begin
                        r_cnt   <= CNT_INIT;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_fall) begin
                        r_pause <= 1'b0;
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        r_access <= 1'b1;
                        r_wait   <= 1'b0;
                        r_state  <= S_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ACTIVE: begin
                    // The cycle after an operation still shows wait, so
                    // strobes are only taken once wait has dropped.
                    if (w_end) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_wait <= 1'b0;
                        if (!r_wait && r_mode_dl && bus.ioctl_write
                            && w_in_rng) begin
                            r_addr  <= bus.ioctl_addr[6:0];
                            r_wdata <= bus.ioctl_dout;
                            r_wait  <= 1'b1;
                            r_state <= S_WR;
                        end else if (!r_wait && !r_mode_dl
                                     && bus.ioctl_rd) begin
                            if (w_in_rng) begin
                                r_addr  <= bus.ioctl_addr[6:0];
                                r_wait  <= 1'b1;
                                r_state <= S_RD0;
                            end else begin
                                r_din <= 8'hFF;
                            end
                        end
                    end
                end
                S_WR: begin
                    r_write        <= 1'b1;
                    r_mask[r_addr] <= 1'b1;
                    r_end          <= r_end | w_fall;
                    r_state        <= S_ACTIVE;
                end
                S_RD0: begin
                    r_end   <= r_end | w_fall;
                    r_state <= S_RD1;
                end
                S_RD1: begin
                    r_din   <= bus.hs_data_out;
                    r_end   <= r_end | w_fall;
                    r_state <= S_ACTIVE;
                end
                S_RELEASE: begin
                    r_access <= 1'b0;
                    r_pause  <= 1'b0;
                    r_wait   <= 1'b0;
                    if (r_mode_dl && w_full) begin
                        r_loaded <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ioctl_din  = r_din;
    assign bus.ioctl_wait = r_wait;
    assign bus.hs_access  = r_access;
    assign bus.hs_address = r_addr;
    assign bus.hs_data_in = r_wdata;
    assign bus.hs_write   = r_write;
    assign pause_req      = r_pause;
    assign hs_loaded      = r_loaded;

endmodule

// File: tb/tb_hiscore_ctrl.sv
// Directed bench for hiscore_ctrl: table-driven upload reads plus
// hand-written download, abort, overlap and reset sequences.
module tb_hiscore_ctrl;

    logic clk;
    logic reset_n;
    logic vblank;
    logic pause_req;
    logic hs_loaded;

    int checks;
    int errors;
    int wr_cnt;

    hiscore_ctrl_if bus ();

    hiscore_ctrl #(
        .HS_INDEX(8'd4),
        .HS_BYTES(128),
        .SETTLE  (16)
    ) dut (
        .clk_12   (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .vblank   (vblank),
        .pause_req(pause_req),
        .hs_loaded(hs_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core RAM model: data is the inverted address, one cycle late.
    always @(posedge clk) bus.hs_data_out <= ~{1'b0, bus.hs_address};

    // Count write pulses seen by the core.
    always @(negedge clk) if (bus.hs_write) wr_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        int          waits;
    } rd_vec_t;

    rd_vec_t rv[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic open_session(input logic dl, input logic ul);
        int n;
        bus.ioctl_index    = 8'd4;
        bus.ioctl_download = dl;
        bus.ioctl_upload   = ul;
        tick;
        chk("pause_req_start", 32'(pause_req), 1);
        chk("wait_start", 32'(bus.ioctl_wait), 1);
        chk("access_pre", 32'(bus.hs_access), 0);
        vblank = 1'b1;
        n = 0;
        while (n < 40 && !bus.hs_access) begin
            tick;
            n++;
        end
        chk("vblank_to_access", n, 17);
        chk("wait_active", 32'(bus.ioctl_wait), 0);
        vblank = 1'b0;
    endtask

    task automatic close_session;
        int n;
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        n = 0;
        while (n < 10 && bus.hs_access) begin
            tick;
            n++;
        end
        chk("end_to_release", n, 2);
        chk("pause_release", 32'(pause_req), 0);
        chk("wait_release", 32'(bus.ioctl_wait), 0);
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                           input logic acc);
        bus.ioctl_addr  = a;
        bus.ioctl_dout  = d;
        bus.ioctl_write = 1'b1;
        tick;
        bus.ioctl_write = 1'b0;
        chk("wr_wait1", 32'(bus.ioctl_wait), 32'(acc));
        chk("wr_nopulse", 32'(bus.hs_write), 0);
        tick;
        chk("wr_pulse", 32'(bus.hs_write), 32'(acc));
        if (acc) begin
            chk("wr_wait2", 32'(bus.ioctl_wait), 1);
            chk("wr_addr", 32'(bus.hs_address), 32'(a[6:0]));
            chk("wr_data", 32'(bus.hs_data_in), 32'(d));
        end
        tick;
        chk("wr_wait_done", 32'(bus.ioctl_wait), 0);
        chk("wr_pulse_done", 32'(bus.hs_write), 0);
    endtask

    task automatic rd_byte(input rd_vec_t v);
        int n;
        bus.ioctl_addr = v.addr;
        bus.ioctl_rd   = 1'b1;
        tick;
        bus.ioctl_rd = 1'b0;
        n = 0;
        while (n < 10 && bus.ioctl_wait) begin
            n++;
            tick;
        end
        chk("rd_waits", n, v.waits);
        chk("rd_din", 32'(bus.ioctl_din), 32'(v.din));
        tick;
        chk("rd_din_hold", 32'(bus.ioctl_din), 32'(v.din));
    endtask

    initial begin
        int base;
        logic saw;
        logic [7:0] last_din;

        rv[0] = '{addr: 25'd0,   din: 8'hFF, waits: 3};
        rv[1] = '{addr: 25'd5,   din: 8'hFA, waits: 3};
        rv[2] = '{addr: 25'd127, din: 8'h80, waits: 3};
        rv[3] = '{addr: 25'd200, din: 8'hFF, waits: 0};
        rv[4] = '{addr: 25'd64,  din: 8'hBF, waits: 3};
        rv[5] = '{addr: 25'd128, din: 8'hFF, waits: 0};

        checks = 0;
        errors = 0;
        wr_cnt = 0;
        reset_n            = 1'b0;
        vblank             = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_write    = 1'b0;
        bus.ioctl_rd       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        repeat (3) tick;
        chk("rst_din", 32'(bus.ioctl_din), 0);
        chk("rst_wait", 32'(bus.ioctl_wait), 0);
        chk("rst_pause", 32'(pause_req), 0);
        chk("rst_access", 32'(bus.hs_access), 0);
        chk("rst_addr", 32'(bus.hs_address), 0);
        chk("rst_wdata", 32'(bus.hs_data_in), 0);
        chk("rst_write", 32'(bus.hs_write), 0);
        chk("rst_loaded", 32'(hs_loaded), 0);
        reset_n = 1'b1;
        tick;

        // Download at a foreign index is ignored entirely.
        base = wr_cnt;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick;
        chk("idx0_pause", 32'(pause_req), 0);
        chk("idx0_wait", 32'(bus.ioctl_wait), 0);
        vblank = 1'b1;
        repeat (20) tick;
        vblank = 1'b0;
        wr_byte(25'd1, 8'h5B, 1'b0);
        chk("idx0_access", 32'(bus.hs_access), 0);
        chk("idx0_wrcnt", wr_cnt - base, 0);
        bus.ioctl_download = 1'b0;
        tick;

        // Partial download leaves hs_loaded clear.
        base = wr_cnt;
        open_session(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            wr_byte(25'(i), 8'(i) ^ 8'h5A, 1'b1);
        end
        close_session;
        chk("part_wrcnt", wr_cnt - base, 100);
        chk("part_loaded", 32'(hs_loaded), 0);
        tick;

        // Full download, with an out-of-range write dropped.
        base = wr_cnt;
        open_session(1'b1, 1'b0);
        wr_byte(25'd130, 8'h11, 1'b0);
        for (int i = 0; i < 128; i++) begin
            wr_byte(25'(i), 8'(i) ^ 8'h5A, 1'b1);
        end
        close_session;
        chk("full_wrcnt", wr_cnt - base, 128);
        chk("full_loaded", 32'(hs_loaded), 1);
        tick;

        // Upload reads from the vector table.
        open_session(1'b0, 1'b1);
        foreach (rv[i]) rd_byte(rv[i]);
        last_din = rv[5].din;
        close_session;
        tick;

        // Session ends during PAUSE.
        bus.ioctl_index    = 8'd4;
        bus.ioctl_download = 1'b1;
        tick;
        chk("abort_pause_on", 32'(pause_req), 1);
        repeat (3) tick;
        bus.ioctl_download = 1'b0;
        tick;
        chk("abort_pause_off", 32'(pause_req), 0);
        chk("abort_wait_off", 32'(bus.ioctl_wait), 0);
        vblank = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (bus.hs_access || pause_req) saw = 1'b1;
        end
        vblank = 1'b0;
        chk("abort_no_access", 32'(saw), 0);
        tick;

        // Both rise together: download wins, reads ignored.
        base = wr_cnt;
        open_session(1'b1, 1'b1);
        bus.ioctl_addr = 25'd3;
        bus.ioctl_rd   = 1'b1;
        tick;
        bus.ioctl_rd = 1'b0;
        chk("both_rd_wait", 32'(bus.ioctl_wait), 0);
        repeat (3) tick;
        chk("both_rd_wait2", 32'(bus.ioctl_wait), 0);
        chk("both_rd_din", 32'(bus.ioctl_din), 32'(last_din));
        wr_byte(25'd7, 8'h5D, 1'b1);
        close_session;
        chk("both_wrcnt", wr_cnt - base, 1);
        tick;

        // Asynchronous reset while the write pulse is high.
        open_session(1'b1, 1'b0);
        bus.ioctl_addr  = 25'd9;
        bus.ioctl_dout  = 8'h53;
        bus.ioctl_write = 1'b1;
        tick;
        bus.ioctl_write = 1'b0;
        chk("rstwr_wait", 32'(bus.ioctl_wait), 1);
        tick;
        chk("rstwr_pulse", 32'(bus.hs_write), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstwr_write0", 32'(bus.hs_write), 0);
        chk("rstwr_access0", 32'(bus.hs_access), 0);
        chk("rstwr_pause0", 32'(pause_req), 0);
        chk("rstwr_wait0", 32'(bus.ioctl_wait), 0);
        chk("rstwr_loaded0", 32'(hs_loaded), 0);
        chk("rstwr_addr0", 32'(bus.hs_address), 0);
        bus.ioctl_download = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
        tick;

        base = wr_cnt;
        open_session(1'b1, 1'b0);
        wr_byte(25'd0, 8'h5A, 1'b1);
        wr_byte(25'd1, 8'h5B, 1'b1);
        close_session;
        chk("post_rst_wrcnt", wr_cnt - base, 2);
        chk("post_rst_loaded", 32'(hs_loaded), 0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
